// File: rtl/binary_down_counter_4_par_load_if.sv
// Load/count bus of the parallel-load down-counter.
// The master drives the load value and the controls; the slave returns the
// count value together with the borrow-out and zero flags.
interface binary_down_counter_4_par_load_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] IN;
    logic             Load;
    logic             Count;
    logic             Reload_En;
    logic [WIDTH-1:0] A;
    logic             BO;
    logic             Zero;

    modport master (
        output IN,
        output Load,
        output Count,
        output Reload_En,
        input  A,
        input  BO,
        input  Zero
    );

    modport slave (
        input  IN,
        input  Load,
        input  Count,
        input  Reload_En,
        output A,
        output BO,
        output Zero
    );
endinterface

// File: rtl/binary_down_counter_4_par_load.sv
// WIDTH-bit binary down-counter with parallel load, borrow-out and optional
// auto-reload on underflow. Load also captures the reload period R, so a
// single load is enough to turn the block into a free-running divider.
// BO of one stage can drive Count of the next stage to build wider counters.
module binary_down_counter_4_par_load #(
    parameter int WIDTH = 4
) (
    input  logic                                  CLK,
    input  logic                                  Clr,
    binary_down_counter_4_par_load_if.slave       bus
);

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic             zero;
    logic             underflow;

    // Value taken by A when a count is requested at zero: the stored period
    // when auto-reload is selected, otherwise a plain modulo wrap to all-ones.
    function automatic logic [WIDTH-1:0] underflow_value(
        input logic             reload_en,
        input logic [WIDTH-1:0] period
    );
        return reload_en ? period : ALL_ONES;
    endfunction

    assign zero      = (a_q == '0);
    assign underflow = bus.Count & ~bus.Load & zero;

    // Next-state selection: load beats count; count either decrements or,
    // at zero, re-arms from R or wraps.
    always_comb begin
        a_d = a_q;
        r_d = r_q;
        if (bus.Load) begin
            a_d = bus.IN;
            r_d = bus.IN;
        end else if (bus.Count) begin
            if (zero) begin
                a_d = underflow_value(bus.Reload_En, r_q);
            end else begin
                a_d = a_q - ONE;
            end
        end
    end

    // Count and reload registers; Clr clears both without waiting for CLK.
    always_ff @(posedge CLK or negedge Clr) begin
        if (!Clr) begin
            a_q <= '0;
            r_q <= '0;
        end else begin
            a_q <= a_d;
            r_q <= r_d;
        end
    end

    assign bus.A    = a_q;
    assign bus.Zero = zero;
    assign bus.BO   = underflow;

endmodule

// File: doc/binary_down_counter_4_par_load.md
Name: binary_down_counter_4_par_load

Overview:
- Synchronous 4-bit binary down-counter with parallel load, borrow-out and optional auto-reload.
- Counterpart of the team's up-counter with parallel load: same load/count interface, counting in the opposite direction.
- Cascadable: BO of one stage drives Count of the next stage.
- Used as a programmable divider or timer. Load a period value once; with Reload_En high the block re-arms itself on every underflow.

Parameters:
- WIDTH, 4, counter and load-value width in bits.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Clr  input  1  asynchronous active-low reset; clears A and the reload register immediately.
- IN  input  WIDTH  parallel load value.
- Load  input  1  synchronous parallel load; priority over Count.
- Count  input  1  count-down enable.
- Reload_En  input  1  auto-reload select on underflow: 1 = reload from the stored value R, 0 = wrap to all-ones.
- A  output  WIDTH  current count value, registered.
- BO  output  1  borrow-out, combinational: Count & ~Load & (A == 0).
- Zero  output  1  combinational: A == 0.

Behaviour:
- Reset (Clr = 0, asynchronous, independent of CLK):
  - A = 0, internal reload register R = 0.
  - Zero = 1; BO = Count & ~Load.
  - State is held while Clr = 0. Normal operation resumes on the first rising CLK edge after Clr returns to 1.
- Rising-edge update, in priority order with Clr = 1:
  1. Load = 1: A <= IN and R <= IN. Count is ignored.
  2. Load = 0, Count = 1, A != 0: A <= A - 1. R is unchanged.
  3. Load = 0, Count = 1, A == 0 (underflow):
     - Reload_En = 1: A <= R.
     - Reload_En = 0: A <= {WIDTH{1'b1}}, i.e. 4'b1111.
  4. Load = 0, Count = 0: A holds. BO = 0.
- Latency: A changes one cycle after Load or Count is sampled. There is no pipeline stage between A and the output.
- Arithmetic is modulo 2^WIDTH. There is no saturation.
- BO rules:
  - BO is high for exactly the cycle in which A == 0 and a decrement or underflow is taking place.
  - BO is suppressed whenever Load = 1.
- Cascading: connect BO of stage n to Count of stage n+1. Load and Clr are shared across stages.
- Auto-reload with R == 0 and Reload_En = 1: A stays 0 and BO is high every cycle that Count = 1 (divide-by-1).
- Period with Reload_En = 1 and loaded value N: BO pulses once every N+1 counting cycles.
- Load and underflow in the same cycle: Load wins, BO = 0, and R is updated.
- Reset mid-count: A and R clear within the same cycle. A previously loaded period is lost and must be reloaded.
- Reload_En is sampled only at the underflow edge. Changing it at any other time has no effect.

Test Plan:
1. Reset and wrap (CLK period 10, Load = 0, Count = 1, Reload_En = 0): hold Clr = 0 for 5, then release.
   - During reset: A = 0, Zero = 1, BO = 1.
   - First edge after release: A = 15, BO = 0.
   - Following edges: A counts 14, 13, ... down to 0, then wraps to 15 with BO high for the cycle at 0.
2. Parallel load then count (Reload_En = 0): Load = 1 with IN = 4'b1001 for one cycle, then Load = 0.
   - Load edge: A = 9.
   - Counting edges: A = 8, 7, ..., 0; BO high for the single cycle at A = 0; next edge A = 15.
3. Auto-reload: load IN = 3, Reload_En = 1, Count = 1.
   - A sequence: 3, 2, 1, 0, 3, 2, 1, 0, ...
   - BO pulses every 4 cycles.
   - Load IN = 5 mid-sequence: the next reload period becomes 6 cycles.
4. Hold and priority:
   - Count = 0 for 20: A is frozen and BO = 0.
   - Load = 1 with Count = 1 while A = 0: A = IN and BO = 0 in that cycle.
5. Async reset mid-operation: assert Clr = 0 between clock edges while A = 6 with auto-reload active.
   - A = 0 immediately, without waiting for a clock edge.
   - After release with Reload_En = 1 and R = 0: A stays 0 and BO is high every counting cycle.
6. Two-stage cascade (WIDTH = 4 each, Reload_En = 0): load 8'h10 across both stages, then count.
   - Combined value steps 8'h10 -> 8'h0F -> ... -> 8'h00 -> 8'hFF.
   - Upper-stage BO is high only on the cycle where the combined value is 8'h00.
